// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte engine: FSM states, quarter
// phases and acknowledge bus levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Named I2C_ACK/I2C_NACK so they do not collide with the ACK state literal.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: counts 0..CLK_DIV-1 and ticks on the last count.
// Clr holds it at zero while idle; Stall holds it at zero while SCL is stretched.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clr,
    input  logic Stall,
    output logic Tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    assign Tick = !Clr && !Stall && (cnt == W'(CLK_DIV - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (Clr || Stall || Tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_byte_engine.sv
// Bit-level I2C master: optional START, 8 data bits, ACK slot, optional STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL in the q2 phases.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250,
    parameter int SIZE    = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic            Start_cond,
    input  logic            Stop_cond,
    input  logic            Rw,
    input  logic [SIZE-1:0] Data_in,
    input  logic            Ack_in,
    input  logic            Scl_i,
    input  logic            Sda_i,
    output logic            Scl_oe,
    output logic            Sda_oe,
    output logic            Busy,
    output logic            Done,
    output logic [SIZE-1:0] Data_out,
    output logic            Ack_out
);

    state_t          state, nxt_state;
    logic [1:0]      q, nxt_q;
    logic [2:0]      bit_cnt, nxt_cnt;
    logic [SIZE-1:0] tx_r, tx_e;
    logic            rw_r, ack_r, stop_r;
    logic            rw_e, ack_e, stop_e;
    logic            accept, finish, tick, stall, upd;
    logic [1:0]      drv;

    assign accept = (state == IDLE) && Start;
    assign tx_e   = accept ? Data_in   : tx_r;
    assign rw_e   = accept ? Rw        : rw_r;
    assign ack_e  = accept ? Ack_in    : ack_r;
    assign stop_e = accept ? Stop_cond : stop_r;
    assign upd    = accept || tick;

`ifdef I2C_CLK_STRETCH_EN
    assign stall = ((state == DATA) || (state == ACK) || (state == STOP)) && (q == Q2) && !Scl_i;
`else
    assign stall = 1'b0 & Scl_i;
`endif

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (state == IDLE),
        .Stall (stall),
        .Tick  (tick)
    );

    always_comb begin
        nxt_state = state;
        nxt_q     = q;
        nxt_cnt   = bit_cnt;
        finish    = 1'b0;
        if (state == IDLE) begin
            if (Start) begin
                nxt_state = Start_cond ? START : DATA;
                nxt_q     = Q0;
                nxt_cnt   = 3'd7;
            end
        end else if (tick) begin
            nxt_q = q + 2'd1;
            if (q == Q3) begin
                case (state)
                    START: begin
                        nxt_state = DATA;
                        nxt_cnt   = 3'd7;
                    end
                    DATA: begin
                        if (bit_cnt == 3'd0) nxt_state = ACK;
                        else                 nxt_cnt   = bit_cnt - 3'd1;
                    end
                    ACK: begin
                        if (stop_r) begin
                            nxt_state = STOP;
                        end else begin
                            nxt_state = IDLE;
                            finish    = 1'b1;
                        end
                    end
                    default: begin
                        nxt_state = IDLE;
                        finish    = 1'b1;
                    end
                endcase
            end
        end
    end

    // Line drive {Scl_oe, Sda_oe} for the phase being entered.
    always_comb begin
        drv = {Scl_oe, Sda_oe};
        case (nxt_state)
            IDLE:  drv = {~stop_e, 1'b0};
            START: begin
                case (nxt_q)
                    Q0:      drv = {Scl_oe, 1'b0};
                    Q1:      drv = 2'b00;
                    default: drv = 2'b01;
                endcase
            end
            DATA, ACK: begin
                case (nxt_q)
                    Q0: drv = {1'b1, (nxt_state == DATA) ? (~rw_e & ~tx_e[nxt_cnt])
                                                         : (rw_e & ~ack_e)};
                    Q1:      drv = {1'b1, Sda_oe};
                    default: drv = {1'b0, Sda_oe};
                endcase
            end
            STOP: begin
                case (nxt_q)
                    Q0, Q1:  drv = 2'b11;
                    Q2:      drv = 2'b01;
                    default: drv = 2'b00;
                endcase
            end
            default: drv = 2'b00;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            q        <= Q0;
            bit_cnt  <= 3'd0;
            tx_r     <= '0;
            rw_r     <= 1'b0;
            ack_r    <= I2C_NACK;
            stop_r   <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Data_out <= '0;
            Ack_out  <= I2C_NACK;
            Scl_oe   <= 1'b0;
            Sda_oe   <= 1'b0;
        end else begin
            state   <= nxt_state;
            q       <= nxt_q;
            bit_cnt <= nxt_cnt;
            Done    <= finish;
            if (accept) begin
                tx_r   <= Data_in;
                rw_r   <= Rw;
                ack_r  <= Ack_in;
                stop_r <= Stop_cond;
                Busy   <= 1'b1;
            end
            if (finish) Busy <= 1'b0;
            if (upd) {Scl_oe, Sda_oe} <= drv;
            // Bus is sampled on the tick that ends q2, i.e. mid SCL-high.
            if (tick && (q == Q2)) begin
                if ((state == DATA) && rw_r)  Data_out <= {Data_out[SIZE-2:0], Sda_i};
                if ((state == ACK)  && !rw_r) Ack_out  <= Sda_i;
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Bench for i2c_byte_engine (CLK_DIV=4) with an open-drain bus and slave model.
// Build with I2C_CLK_STRETCH_EN defined to include the clock-stretch scenario.
module tb_i2c_byte_engine;

  localparam int CLK_DIV = 4;
  localparam int EW = 25;  // {latency[15:0], rw, value[7:0]}

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Start = 1'b0, Start_cond = 1'b0, Stop_cond = 1'b0, Rw = 1'b0, Ack_in = 1'b1;
  logic [7:0] Data_in = 8'h00;
  logic Scl_i, Sda_i, Scl_oe, Sda_oe, Busy, Done, Ack_out;
  logic [7:0] Data_out;

  logic scl_force = 1'b0, rd_mode = 1'b0, slave_ack = 1'b0, slave_pull;
  logic [7:0] rd_byte = 8'h00;
  logic [15:0] bit_at = '0;
  logic scl_prev = 1'b1;
  int held_idx = 0, rise_cnt = 0;
  int cyc = 0, start_cyc = 0, xfer_id = 0, seen_id = 0, done_cnt = 0;
  int n_checks = 0, n_fails = 0;
  int d0;
  logic [EW-1:0] exp_q[$];

  i2c_byte_engine #(.CLK_DIV(CLK_DIV), .SIZE(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Start_cond(Start_cond), .Stop_cond(Stop_cond),
    .Rw(Rw), .Data_in(Data_in), .Ack_in(Ack_in), .Scl_i(Scl_i), .Sda_i(Sda_i),
    .Scl_oe(Scl_oe), .Sda_oe(Sda_oe), .Busy(Busy), .Done(Done),
    .Data_out(Data_out), .Ack_out(Ack_out)
  );

  // clock / bus
  always #5 Clk = ~Clk;

  assign slave_pull = rd_mode ? ((held_idx < 8) ? !rd_byte[7 - held_idx] : 1'b0)
                              : (slave_ack && (held_idx == 8));
  assign Scl_i = ~Scl_oe & ~scl_force;
  assign Sda_i = ~Sda_oe & ~slave_pull;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] log_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = bit_at[i];
    return b;
  endfunction

  // transfer bookkeeping at the accepting edge
  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (!Rst && Start && !Busy) begin
      start_cyc = cyc;
      xfer_id++;
    end
  end

  // bus monitor, slave bit pointer and scoreboard
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    if (xfer_id != seen_id) begin
      seen_id  = xfer_id;
      rise_cnt = 0;
      held_idx = 0;
      bit_at   = '0;
    end
    if (!scl_prev && Scl_i) begin
      if (rise_cnt < 16) bit_at[rise_cnt] = Sda_i;
      rise_cnt++;
    end
    if (scl_prev && !Scl_i) held_idx = rise_cnt;
    scl_prev = Scl_i;
    if (!Rst && Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc - start_cyc, {16'd0, e[24:9]});
        if (e[8]) check("data_out", {24'd0, Data_out}, {24'd0, e[7:0]});
        else      check("ack_out", {31'd0, Ack_out}, {31'd0, e[0]});
      end
    end
  end

  // driver tasks
  task automatic issue(input logic st, input logic sp, input logic rw, input logic [7:0] din,
                       input logic ackin, input logic sack, input logic [7:0] rbyte,
                       input int lat, input logic push);
    @(negedge Clk);
    rd_mode = rw; slave_ack = sack; rd_byte = rbyte;
    Start = 1'b1; Start_cond = st; Stop_cond = sp; Rw = rw; Data_in = din; Ack_in = ackin;
    if (push) exp_q.push_back({lat[15:0], rw, rw ? rbyte : {7'd0, ~sack}});
    @(posedge Clk); #1;
    Start = 1'b0;
    check("busy_rise", {31'd0, Busy}, 32'd1);
  endtask

  task automatic wait_done(input int base, input string name);
    int n = 0;
    while (done_cnt == base && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_done_seen"}, {31'd0, done_cnt != base}, 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_data_out", {24'd0, Data_out}, 32'd0);
    check("rst_ack_out", {31'd0, Ack_out}, 32'd1);
    check("rst_scl_oe", {31'd0, Scl_oe}, 32'd0);
    check("rst_sda_oe", {31'd0, Sda_oe}, 32'd0);

    // write 0xA5, START+STOP, slave ACKs
    d0 = done_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 176, 1'b1);
    wait_done(d0, "t1");
    check("t1_bits", {24'd0, log_byte()}, 32'hA5);
    repeat (4) @(negedge Clk);
    check("t1_scl_released", {31'd0, Scl_oe}, 32'd0);
    check("t1_sda_released", {31'd0, Sda_oe}, 32'd0);

    // read 0x3C, master NACK, no START/STOP
    d0 = done_cnt;
    issue(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 144, 1'b1);
    wait_done(d0, "t2");
    check("t2_bus_bits", {24'd0, log_byte()}, 32'h3C);
    check("t2_ack_slot_released", {31'd0, bit_at[8]}, 32'd1);
    repeat (4) @(negedge Clk);
    check("t2_scl_held_low", {31'd0, Scl_oe}, 32'd1);
    check("t2_sda_released", {31'd0, Sda_oe}, 32'd0);

    // write 0xFF, slave NACKs, STOP only
    d0 = done_cnt;
    issue(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 160, 1'b1);
    wait_done(d0, "t3");
    check("t3_bits", {24'd0, log_byte()}, 32'hFF);

    // Start pulsed while busy must be ignored
    d0 = done_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 176, 1'b1);
    repeat (40) @(negedge Clk);
    Start = 1'b1; Start_cond = 1'b0; Rw = 1'b1; Data_in = 8'h00;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(d0, "t4");
    check("t4_bits", {24'd0, log_byte()}, 32'h5A);
    repeat (200) @(negedge Clk);
    check("t4_single_done", done_cnt, d0 + 1);

    // reset during bit 4 of a 0x00 write
    d0 = done_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    repeat (66) @(posedge Clk);
    #2;
    check("t5_scl_low_before_rst", {31'd0, Scl_oe}, 32'd1);
    check("t5_sda_low_before_rst", {31'd0, Sda_oe}, 32'd1);
    Rst = 1'b1;
    #1;
    check("t5_rst_scl_oe", {31'd0, Scl_oe}, 32'd0);
    check("t5_rst_sda_oe", {31'd0, Sda_oe}, 32'd0);
    check("t5_rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (100) @(negedge Clk);
    check("t5_no_done", done_cnt, d0);
    d0 = done_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 176, 1'b1);
    wait_done(d0, "t5b");
    check("t5b_bits", {24'd0, log_byte()}, 32'h81);

`ifdef I2C_CLK_STRETCH_EN
    // slave holds SCL low for 10 cycles at bit 3 q2
    d0 = done_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 186, 1'b1);
    repeat (87) @(posedge Clk);
    #1 scl_force = 1'b1;
    repeat (10) @(posedge Clk);
    #1 scl_force = 1'b0;
    wait_done(d0, "t6");
    check("t6_bits", {24'd0, log_byte()}, 32'hA5);
`endif

    repeat (10) @(negedge Clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
